// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg : shared RV32I decode constants, immediate kinds and E-stage ctrl.
// Rev 1.0
// ============================================================================
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
   localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_src_e;

   // Every field zero is a harmless bubble.
   typedef struct packed {
      logic       regWrite;
      logic       jump;
      logic       branch;
      logic       ALUsrc;
      logic       jalr;
      logic       lui;
      logic [1:0] resultSrc;
      logic [3:0] ALUctrl;
      logic [2:0] R_size;
      logic [2:0] DMem_size;
   } ctrl_e_t;

   function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
      logic [3:0] op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// decode_stage_pipe_if : IF/ID, writeback and D->E boundary signal bundle.
// Rev 1.0
// ============================================================================
interface decode_stage_pipe_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic [XLEN-1:0]       instr_D;
   logic [XLEN-1:0]       pc_D;
   logic                  valid_D;
   logic                  flush_E;
   logic                  regWrite_W;
   logic [REG_ADDR_W-1:0] Rd_W;
   logic [XLEN-1:0]       result_W;

   logic                  stall_D;
   logic                  valid_E;
   logic                  regWrite_E;
   logic                  jump_E;
   logic                  branch_E;
   logic                  ALUsrc_E;
   logic                  jalr_E;
   logic                  lui_E;
   logic [1:0]            resultSrc_E;
   logic [3:0]            ALUctrl_E;
   logic [2:0]            R_size_E;
   logic [2:0]            DMem_size_E;
   logic [REG_ADDR_W-1:0] Rd_E;
   logic [REG_ADDR_W-1:0] Rs1_E;
   logic [REG_ADDR_W-1:0] Rs2_E;
   logic [XLEN-1:0]       RD1_E;
   logic [XLEN-1:0]       RD2_E;
   logic [XLEN-1:0]       ImmExt_E;
   logic [XLEN-1:0]       pc_E;
   logic [XLEN-1:0]       a0;

   modport master (
      output instr_D, pc_D, valid_D, flush_E, regWrite_W, Rd_W, result_W,
      input  stall_D, valid_E, regWrite_E, jump_E, branch_E, ALUsrc_E, jalr_E, lui_E,
             resultSrc_E, ALUctrl_E, R_size_E, DMem_size_E, Rd_E, Rs1_E, Rs2_E,
             RD1_E, RD2_E, ImmExt_E, pc_E, a0
   );

   modport slave (
      input  instr_D, pc_D, valid_D, flush_E, regWrite_W, Rd_W, result_W,
      output stall_D, valid_E, regWrite_E, jump_E, branch_E, ALUsrc_E, jalr_E, lui_E,
             resultSrc_E, ALUctrl_E, R_size_E, DMem_size_E, Rd_E, Rs1_E, Rs2_E,
             RD1_E, RD2_E, ImmExt_E, pc_E, a0
   );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// control_unit : RV32I opcode/funct decode into E-stage control fields.
// Rev 1.0
// ============================================================================
module control_unit
   import riscv_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output ctrl_e_t    ctrl_o,
   output imm_src_e   imm_src_o
);
   always_comb begin
      ctrl_o    = '0;
      imm_src_o = IMM_I;
      case (op_i)
         OP_R: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.ALUctrl  = alu_op(funct3_i, funct7b5_i);
         end
         OP_I: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.ALUsrc   = 1'b1;
            ctrl_o.ALUctrl  = alu_op(funct3_i, (funct3_i == 3'b101) && funct7b5_i);
         end
         OP_LOAD: begin
            ctrl_o.regWrite  = 1'b1;
            ctrl_o.ALUsrc    = 1'b1;
            ctrl_o.resultSrc = RESULT_SRC_MEM;
            ctrl_o.R_size    = funct3_i;
            ctrl_o.DMem_size = funct3_i;
         end
         OP_STORE: begin
            ctrl_o.ALUsrc    = 1'b1;
            ctrl_o.DMem_size = funct3_i;
            imm_src_o        = IMM_S;
         end
         OP_BRANCH: begin
            ctrl_o.branch  = 1'b1;
            ctrl_o.ALUctrl = ALU_SUB;
            imm_src_o      = IMM_B;
         end
         OP_JAL: begin
            ctrl_o.regWrite  = 1'b1;
            ctrl_o.jump      = 1'b1;
            ctrl_o.resultSrc = RESULT_SRC_PC4;
            imm_src_o        = IMM_J;
         end
         OP_JALR: begin
            ctrl_o.regWrite  = 1'b1;
            ctrl_o.jump      = 1'b1;
            ctrl_o.jalr      = 1'b1;
            ctrl_o.ALUsrc    = 1'b1;
            ctrl_o.resultSrc = RESULT_SRC_PC4;
         end
         OP_LUI: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.lui      = 1'b1;
            ctrl_o.ALUsrc   = 1'b1;
            imm_src_o       = IMM_U;
         end
         OP_AUIPC: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.ALUsrc   = 1'b1;
            imm_src_o       = IMM_U;
         end
         default: ctrl_o = '0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// ============================================================================
// regfile_bypass : 2R1W register file, x0 hardwired, write-through reads.
// Rev 1.0
// ============================================================================
module regfile_bypass #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int A0_IDX     = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   output logic [XLEN-1:0]       rd1_o,
   output logic [XLEN-1:0]       rd2_o,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic [XLEN-1:0]       wd_i,
   output logic [XLEN-1:0]       a0_o
);
   localparam int                    NREGS   = 2 ** REG_ADDR_W;
   localparam logic [REG_ADDR_W-1:0] A0_ADDR = REG_ADDR_W'(A0_IDX);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            w_wr;

   assign w_wr = we_i && (rd_i != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (w_wr) begin
         regs_q[rd_i] <= wd_i;
      end
   end

   assign rd1_o = (rs1_i == '0)               ? '0   :
                  (w_wr && (rd_i == rs1_i))   ? wd_i : regs_q[rs1_i];
   assign rd2_o = (rs2_i == '0)               ? '0   :
                  (w_wr && (rd_i == rs2_i))   ? wd_i : regs_q[rs2_i];

   // Architectural view only; deliberately not bypassed.
   assign a0_o = regs_q[A0_ADDR];
endmodule
`default_nettype wire

// File: rtl/sign_extend.sv
`default_nettype none
// ============================================================================
// sign_extend : immediate extraction for I/S/B/U/J, sign-extended to XLEN.
// Rev 1.0
// ============================================================================
module sign_extend
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  imm_src_e        imm_src_i,
   output logic [XLEN-1:0] imm_ext_o
);
   logic signed [31:0] w_imm;

   always_comb begin
      w_imm = '0;
      case (imm_src_i)
         IMM_I:   w_imm = {{20{instr_i[31]}}, instr_i[31:20]};
         IMM_S:   w_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         IMM_B:   w_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
         IMM_U:   w_imm = {instr_i[31:12], 12'b0};
         IMM_J:   w_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
         default: w_imm = '0;
      endcase
   end

   assign imm_ext_o = XLEN'(w_imm);
endmodule
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// decode_stage_pipe : decode, regfile, load-use stall and registered D->E stage.
// Rev 1.0
// ============================================================================
module decode_stage_pipe
   import riscv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int A0_IDX      = 10,
   parameter int LOAD_USE_EN = 1
) (
   input  logic                clk,
   input  logic                rst,
   decode_stage_pipe_if.slave  bus_io
);
   logic [31:0]           w_instr;
   logic [6:0]            w_op;
   logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0]       w_rd1, w_rd2, w_imm;
   ctrl_e_t               w_ctrl;
   imm_src_e              w_imm_src;
   logic                  w_uses_rs1, w_uses_rs2;
   logic                  w_hz, w_stall;

   ctrl_e_t               ctrl_d, ctrl_q;
   logic                  valid_d, valid_q;
   logic [REG_ADDR_W-1:0] rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
   logic [XLEN-1:0]       rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q, pc_d, pc_q;

   assign w_instr = bus_io.instr_D[31:0];
   assign w_op    = w_instr[6:0];
   assign w_rs1   = REG_ADDR_W'(w_instr[19:15]);
   assign w_rs2   = REG_ADDR_W'(w_instr[24:20]);
   assign w_rd    = REG_ADDR_W'(w_instr[11:7]);

   control_unit u_ctrl (
      .op_i       (w_op),
      .funct3_i   (w_instr[14:12]),
      .funct7b5_i (w_instr[30]),
      .ctrl_o     (w_ctrl),
      .imm_src_o  (w_imm_src)
   );

   sign_extend #(.XLEN(XLEN)) u_sext (
      .instr_i    (w_instr),
      .imm_src_i  (w_imm_src),
      .imm_ext_o  (w_imm)
   );

   regfile_bypass #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W),
      .A0_IDX     (A0_IDX)
   ) u_rf (
      .clk   (clk),
      .rst   (rst),
      .rs1_i (w_rs1),
      .rs2_i (w_rs2),
      .rd1_o (w_rd1),
      .rd2_o (w_rd2),
      .we_i  (bus_io.regWrite_W),
      .rd_i  (bus_io.Rd_W),
      .wd_i  (bus_io.result_W),
      .a0_o  (bus_io.a0)
   );

   assign w_uses_rs1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
   assign w_uses_rs2 = (w_op == OP_R) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

   // Only a load still sitting in E can be a hazard; once it moves on, forwarding covers it.
   generate
      if (LOAD_USE_EN != 0) begin : g_load_use_on
         assign w_hz = valid_q && (ctrl_q.resultSrc == RESULT_SRC_MEM) && (rd_q != '0) &&
                       bus_io.valid_D &&
                       ((w_uses_rs1 && (w_rs1 == rd_q)) || (w_uses_rs2 && (w_rs2 == rd_q)));
      end else begin : g_load_use_off
         assign w_hz = 1'b0;
      end
   endgenerate

   assign w_stall        = w_hz && !bus_io.flush_E;
   assign bus_io.stall_D = w_stall;

   always_comb begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd_d    = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      pc_d    = '0;
      if (!bus_io.flush_E && !w_stall && bus_io.valid_D) begin
         valid_d = 1'b1;
         ctrl_d  = w_ctrl;
         rd_d    = w_rd;
         rs1_d   = w_rs1;
         rs2_d   = w_rs2;
         rd1_d   = w_rd1;
         rd2_d   = w_rd2;
         imm_d   = w_imm;
         pc_d    = bus_io.pc_D;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         imm_q   <= imm_d;
         pc_q    <= pc_d;
      end
   end

   assign bus_io.valid_E     = valid_q;
   assign bus_io.regWrite_E  = ctrl_q.regWrite;
   assign bus_io.jump_E      = ctrl_q.jump;
   assign bus_io.branch_E    = ctrl_q.branch;
   assign bus_io.ALUsrc_E    = ctrl_q.ALUsrc;
   assign bus_io.jalr_E      = ctrl_q.jalr;
   assign bus_io.lui_E       = ctrl_q.lui;
   assign bus_io.resultSrc_E = ctrl_q.resultSrc;
   assign bus_io.ALUctrl_E   = ctrl_q.ALUctrl;
   assign bus_io.R_size_E    = ctrl_q.R_size;
   assign bus_io.DMem_size_E = ctrl_q.DMem_size;
   assign bus_io.Rd_E        = rd_q;
   assign bus_io.Rs1_E       = rs1_q;
   assign bus_io.Rs2_E       = rs2_q;
   assign bus_io.RD1_E       = rd1_q;
   assign bus_io.RD2_E       = rd2_q;
   assign bus_io.ImmExt_E    = imm_q;
   assign bus_io.pc_E        = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_pipe : directed checks of decode_stage_pipe (3 configurations).
// Rev 1.0
// ============================================================================
module tb_decode_stage_pipe;
   localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093;
   localparam logic [31:0] ADD_X4_X3   = 32'h0001_8233;
   localparam logic [31:0] ADD_X1_X0   = 32'h0000_00B3;
   localparam logic [31:0] LW_X5       = 32'h0001_2283;
   localparam logic [31:0] LW_X0       = 32'h0001_2003;
   localparam logic [31:0] ADD_X6_X5   = 32'h0012_8333;
   localparam logic [31:0] LUI_X5_1    = 32'h0000_12B7;
   localparam logic [31:0] LUI_X6_28   = 32'h0002_8337;
   localparam logic [31:0] ADDI_X7_1   = 32'h0010_0393;
   localparam logic [31:0] JAL_X1_8    = 32'h0080_00EF;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   decode_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) if0 ();
   decode_stage_pipe_if #(.XLEN(32), .REG_ADDR_W(5)) if1 ();
   decode_stage_pipe_if #(.XLEN(64), .REG_ADDR_W(5)) if2 ();

   decode_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .A0_IDX(10), .LOAD_USE_EN(1)) u_dut (
      .clk(clk), .rst(rst), .bus_io(if0.slave));
   decode_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .A0_IDX(10), .LOAD_USE_EN(0)) u_dut_nolu (
      .clk(clk), .rst(rst), .bus_io(if1.slave));
   decode_stage_pipe #(.XLEN(64), .REG_ADDR_W(5), .A0_IDX(10), .LOAD_USE_EN(1)) u_dut64 (
      .clk(clk), .rst(rst), .bus_io(if2.slave));

   assign if1.instr_D    = if0.instr_D;
   assign if1.pc_D       = if0.pc_D;
   assign if1.valid_D    = if0.valid_D;
   assign if1.flush_E    = if0.flush_E;
   assign if1.regWrite_W = if0.regWrite_W;
   assign if1.Rd_W       = if0.Rd_W;
   assign if1.result_W   = if0.result_W;

   assign if2.instr_D    = {32'h0, if0.instr_D};
   assign if2.pc_D       = {32'h0, if0.pc_D};
   assign if2.valid_D    = if0.valid_D;
   assign if2.flush_E    = if0.flush_E;
   assign if2.regWrite_W = if0.regWrite_W;
   assign if2.Rd_W       = if0.Rd_W;
   assign if2.result_W   = {if0.result_W, if0.result_W};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ins, input logic v, input logic fl);
      if0.instr_D = ins;
      if0.valid_D = v;
      if0.flush_E = fl;
   endtask

   task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
      if0.regWrite_W = we;
      if0.Rd_W       = rd;
      if0.result_W   = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      if0.pc_D = 32'h100;
      drive(ADDI_X1_5, 1'b1, 1'b0);
      wb(1'b0, 5'd0, 32'h0);

      // Reset held two cycles with a valid instruction presented
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("rst_valid_E", if0.valid_E, 0);
         check_eq("rst_a0", if0.a0, 0);
         check_eq("rst_ImmExt_E", if0.ImmExt_E, 0);
         check_eq("rst_Rd_E", if0.Rd_E, 0);
         check_eq("rst_regWrite_E", if0.regWrite_E, 0);
         check_eq("rst_pc_E", if0.pc_E, 0);
      end
      rst = 1'b1;
      tick();
      check_eq("addi_valid_E", if0.valid_E, 1);
      check_eq("addi_ImmExt_E", if0.ImmExt_E, 5);
      check_eq("addi_Rd_E", if0.Rd_E, 1);
      check_eq("addi_regWrite_E", if0.regWrite_E, 1);
      check_eq("addi_ALUsrc_E", if0.ALUsrc_E, 1);
      check_eq("addi_pc_E", if0.pc_E, 32'h100);

      // Write-through into the same-cycle read
      drive(ADD_X4_X3, 1'b1, 1'b0);
      wb(1'b1, 5'd3, 32'hDEAD_BEEF);
      tick();
      check_eq("wt_RD1_E", if0.RD1_E, 32'hDEAD_BEEF);
      check_eq("wt_RD2_E", if0.RD2_E, 0);
      check_eq("wt_Rs1_E", if0.Rs1_E, 3);
      check_eq("wt_Rd_E", if0.Rd_E, 4);
      check_eq("wt64_RD1_E", if2.RD1_E, 64'hDEAD_BEEF_DEAD_BEEF);
      check_eq("wt64_Rd_E", if2.Rd_E, 4);

      drive(ADD_X1_X0, 1'b1, 1'b0);
      wb(1'b1, 5'd0, 32'h1234_5678);
      tick();
      check_eq("x0_RD1_E", if0.RD1_E, 0);
      check_eq("x0_RD2_E", if0.RD2_E, 0);

      drive(ADD_X4_X3, 1'b1, 1'b0);
      wb(1'b0, 5'd0, 32'h0);
      tick();
      check_eq("arr_RD1_E", if0.RD1_E, 32'hDEAD_BEEF);

      // Load-use: one bubble, then the dependent instruction issues
      drive(LW_X5, 1'b1, 1'b0);
      #1 check_eq("lu_pre_stall", if0.stall_D, 0);
      tick();
      check_eq("lw_resultSrc_E", if0.resultSrc_E, 1);
      check_eq("lw_Rd_E", if0.Rd_E, 5);
      check_eq("lw_R_size_E", if0.R_size_E, 2);
      drive(ADD_X6_X5, 1'b1, 1'b0);
      #1;
      check_eq("lu_stall", if0.stall_D, 1);
      check_eq("lu_off_stall", if1.stall_D, 0);
      tick();
      check_eq("lu_bubble_valid_E", if0.valid_E, 0);
      check_eq("lu_bubble_regWrite_E", if0.regWrite_E, 0);
      check_eq("lu_bubble_resultSrc_E", if0.resultSrc_E, 0);
      check_eq("lu_off_valid_E", if1.valid_E, 1);
      #1 check_eq("lu_stall_cleared", if0.stall_D, 0);
      tick();
      check_eq("lu_dep_valid_E", if0.valid_E, 1);
      check_eq("lu_dep_Rd_E", if0.Rd_E, 6);
      check_eq("lu_dep_Rs1_E", if0.Rs1_E, 5);
      check_eq("lu_dep_Rs2_E", if0.Rs2_E, 1);

      // No false stalls
      drive(LW_X5, 1'b1, 1'b0);
      tick();
      drive(LUI_X5_1, 1'b1, 1'b0);
      #1 check_eq("nf_lui1_stall", if0.stall_D, 0);
      tick();
      check_eq("lui_lui_E", if0.lui_E, 1);
      check_eq("lui_ImmExt_E", if0.ImmExt_E, 32'h1000);
      drive(LW_X5, 1'b1, 1'b0);
      tick();
      drive(LUI_X6_28, 1'b1, 1'b0);
      #1 check_eq("nf_lui28_stall", if0.stall_D, 0);
      tick();
      check_eq("lui28_ImmExt_E", if0.ImmExt_E, 32'h0002_8000);
      drive(LW_X5, 1'b1, 1'b0);
      tick();
      drive(ADDI_X7_1, 1'b1, 1'b0);
      #1 check_eq("nf_addi_stall", if0.stall_D, 0);
      tick();
      check_eq("addi7_Rd_E", if0.Rd_E, 7);
      check_eq("addi7_ImmExt_E", if0.ImmExt_E, 1);
      drive(LW_X0, 1'b1, 1'b0);
      tick();
      drive(ADD_X1_X0, 1'b1, 1'b0);
      #1 check_eq("nf_x0_stall", if0.stall_D, 0);
      tick();

      // Jump decode, then flush priority over jump and over load-use
      drive(JAL_X1_8, 1'b1, 1'b0);
      tick();
      check_eq("jal_jump_E", if0.jump_E, 1);
      check_eq("jal_resultSrc_E", if0.resultSrc_E, 2);
      check_eq("jal_ImmExt_E", if0.ImmExt_E, 8);
      drive(JAL_X1_8, 1'b1, 1'b1);
      tick();
      check_eq("fl_jal_valid_E", if0.valid_E, 0);
      check_eq("fl_jal_jump_E", if0.jump_E, 0);
      drive(LW_X5, 1'b1, 1'b0);
      tick();
      drive(ADD_X6_X5, 1'b1, 1'b1);
      #1 check_eq("fl_lu_stall", if0.stall_D, 0);
      tick();
      check_eq("fl_valid_E", if0.valid_E, 0);
      check_eq("fl_branch_E", if0.branch_E, 0);
      check_eq("fl_jump_E", if0.jump_E, 0);
      check_eq("fl_regWrite_E", if0.regWrite_E, 0);

      // a0 mirrors the array one cycle after the write
      drive(32'h0, 1'b0, 1'b0);
      wb(1'b1, 5'd10, 32'h2A);
      #1 check_eq("a0_same_cycle", if0.a0, 0);
      tick();
      check_eq("a0_after", if0.a0, 32'h2A);
      check_eq("a0_bubble_valid_E", if0.valid_E, 0);
      wb(1'b0, 5'd0, 32'h0);

      // Reset asserted during a stall
      drive(LW_X5, 1'b1, 1'b0);
      tick();
      drive(ADD_X6_X5, 1'b1, 1'b0);
      #1 check_eq("rs_stall", if0.stall_D, 1);
      rst = 1'b0;
      tick();
      check_eq("rs_valid_E", if0.valid_E, 0);
      check_eq("rs_Rd_E", if0.Rd_E, 0);
      check_eq("rs_a0", if0.a0, 0);
      rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised next-generation decode stage for the pipelined RV32I core.
- Contains:
  - a parametrised register file with write-through bypass;
  - the existing control_unit and sign_extend decode logic;
  - load-use hazard detection;
  - the registered D→E pipeline boundary with stall, flush and valid tracking.
- Sits between the IF/ID register and the execute stage; all E-side outputs are registers.

Parameters:
- XLEN, 32, datapath width in bits.
- REG_ADDR_W, 5, register index width; register count = 2**REG_ADDR_W.
- A0_IDX, 10, register index mirrored on the a0 output.
- LOAD_USE_EN, 1, 1 enables load-use stall detection; 0 ties stall_D low.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- instr_D  in  XLEN  instruction from IF/ID.
- pc_D  in  XLEN  PC of instr_D.
- valid_D  in  1  instr_D is a real instruction.
- flush_E  in  1  taken branch/jump in E; squash next E contents.
- regWrite_W  in  1  writeback enable.
- Rd_W  in  REG_ADDR_W  writeback destination.
- result_W  in  XLEN  writeback data.
- stall_D  out  1  hold PC and IF/ID (combinational).
- valid_E  out  1  E holds a real instruction.
- regWrite_E, jump_E, branch_E, ALUsrc_E, jalr_E, lui_E  out  1 each  registered control.
- resultSrc_E  out  2  registered result select (2'b01 = load).
- ALUctrl_E  out  4  registered ALU control.
- R_size_E, DMem_size_E  out  3 each  registered size controls.
- Rd_E, Rs1_E, Rs2_E  out  REG_ADDR_W each  registered register indices (for forwarding).
- RD1_E, RD2_E, ImmExt_E, pc_E  out  XLEN each  registered operands.
- a0  out  XLEN  current contents of register A0_IDX.

Behaviour:
- Reset (rst==0 at a clock edge):
  - all registers, including every regfile entry, clear to 0;
  - valid_E=0 and every *_E output is 0;
  - a0=0.
  - Reset overrides stall and flush. Asserting reset mid-stall yields a bubble in E on the next cycle.
- Register file:
  - Write at the clock edge when regWrite_W && Rd_W!=0. Entry 0 always reads 0.
  - Read is combinational, with write-through: if regWrite_W && Rd_W!=0 && Rd_W==rsN, RDN returns result_W in the same cycle.
- Source usage, decoded from the opcode:
  - rs1 unused for LUI, AUIPC and JAL.
  - rs2 used only for R-type, STORE and BRANCH.
- Hazard: hz = LOAD_USE_EN && valid_E && resultSrc_E==2'b01 && Rd_E!=0 && valid_D && ((uses_rs1 && rs1==Rd_E) || (uses_rs2 && rs2==Rd_E)).
- stall_D = hz && !flush_E.
- E register update, in priority order:
  1. flush_E=1: E loads a bubble (valid_E=0, all control 0; data fields don't-care but driven 0).
  2. stall_D=1: E loads a bubble, and upstream holds instr_D, so the same instruction re-decodes next cycle.
  3. valid_D=0: E loads a bubble.
  4. Otherwise E loads the decoded instruction, with valid_E=1.
- Bubble invariant: regWrite_E, branch_E, jump_E and resultSrc_E are all 0 whenever valid_E=0. No side effects from a squashed instruction.
- Latency: decode-to-E is 1 cycle. A load-use pair costs exactly 1 bubble, because the stall clears once the load leaves E.
- Flush and hazard in the same cycle: flush wins and stall_D=0, since the dependent D instruction is itself wrong-path and is squashed upstream.
- a0 reflects the register array contents. It is not bypassed: it updates the cycle after the write.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - RESULT_SRC_MEM=2'b01;
  - a packed struct ctrl_e_t bundling all E control fields, so bubble = '0.
- Sub-modules:
  - regfile_bypass (parametrised array plus write-through) is the natural separate sub-module.
  - control_unit and sign_extend are instantiated unchanged.
  - The hazard logic and the E register stay inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles with instr_D=ADDI x1,x0,5 and valid_D=1 → valid_E=0, a0=0, all *_E outputs 0. Release → next edge valid_E=1, ImmExt_E=5, Rd_E=1.
- Write-through: regWrite_W=1, Rd_W=3, result_W=0xDEADBEEF, with instr_D=ADD x4,x3,x0 in the same cycle → RD1_E=0xDEADBEEF after the edge. A write with Rd_W=0 leaves reads of x0 at 0.
- Load-use: LW x5,0(x2) followed by ADD x6,x5,x1 → stall_D=1 for exactly 1 cycle, and one bubble (valid_E=0, regWrite_E=0) appears between them. With LOAD_USE_EN=0, stall_D stays 0.
- No false stall: LW x5 followed by LUI x5,0x1 or ADDI x7,x0,1 → stall_D=0. LW x0 followed by ADD x1,x0,x0 → stall_D=0.
- Flush priority: flush_E=1 in the same cycle as a load-use hazard → stall_D=0, and next valid_E=0 with branch_E=jump_E=0.
- a0 mirror: write 0x2A to x10 → a0=0x2A from the following cycle. Parametrisation smoke test with XLEN=64, REG_ADDR_W=5 passes the write-through case.
